// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns
// (active-low, a..g with a in the MSB), all-off values and the scan FSM states.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

endpackage

// File: rtl/display_scan_ctrl_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// (10-15) light nothing.
module bcd_seg_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a frame-aligned
// load handshake. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] value,
  output logic [0:6]  SSeg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  scan_state_t state, state_next;

  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [15:0]   display;
  logic [15:0]   pending;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic          digit_blank;
  logic          scanning;
  logic          slot_end;
  logic          wrap;
  logic          accept;
  logic          commit;

  // Scanning is gated by en directly so a falling en blanks on the very next edge.
  assign scanning = (state == SCAN) && en;
  assign slot_end = scanning && (div == DIV_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign accept   = load_valid && load_ready;
  assign commit   = !load_ready && (wrap || state == BLANK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BLANK;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (en)  state_next = SCAN;
      SCAN:    if (!en) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (!scanning) begin
      div <= '0;
      idx <= '0;
    end else if (slot_end) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // load_ready low doubles as "pending holds an uncommitted value".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      display    <= '0;
      load_ready <= 1'b1;
    end else if (commit) begin
      display    <= pending;
      load_ready <= 1'b1;
    end else if (accept) begin
      pending    <= value;
      load_ready <= 1'b0;
    end
  end

  assign cur_digit = display[{idx, 2'b00} +: 4];

  bcd_seg_decode u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    digit_blank = (idx != '0);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= 32'(idx) && display[4*i +: 4] != 4'd0) digit_blank = 1'b0;
    end
  end
`else
  assign digit_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      SSeg       <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (scanning) begin
        an   <= ~(4'b0001 << idx);
        SSeg <= digit_blank ? SEG_OFF : dec_seg;
      end else begin
        an   <= AN_OFF;
        SSeg <= SEG_OFF;
      end
    end
  end

endmodule
